// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage: decodes the instruction, builds ALU operands and
// registers them into the ID/EX pipeline register that drives the ALU directly.

package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output alu_op_t         ex_alu_op,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_illegal,
    output logic [XLEN-1:0] ex_pc
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    alu_op_t         dec_op;
    logic            dec_wb;
    logic            dec_legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];

    // Size casts of signed values sign-extend to XLEN from instr[31].
    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

    function automatic alu_op_t funct3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_a     = '0;
        dec_b     = '0;
        dec_op    = ALU_ADD;
        dec_wb    = 1'b0;
        dec_legal = 1'b1;

        case (opcode)
            OPC_OP: begin
                dec_a  = rs1_data;
                dec_b  = rs2_data;
                dec_wb = 1'b1;
                dec_op = funct3_op(funct3);
                if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else if (funct7 != F7_BASE) begin
                    dec_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_a  = rs1_data;
                dec_b  = imm_i;
                dec_wb = 1'b1;
                dec_op = funct3_op(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_legal = 1'b0;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_op = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_legal = 1'b0;
                    end
                end
            end
            OPC_LUI: begin
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a  = pc;
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_LOAD: begin
                dec_a  = rs1_data;
                dec_b  = imm_i;
                dec_wb = 1'b1;
            end
            OPC_STORE: begin
                dec_a = rs1_data;
                dec_b = imm_s;
            end
            OPC_BRANCH: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                case (funct3[2:1])
                    2'b00:   dec_op = ALU_SUB;
                    2'b10:   dec_op = ALU_SLT;
                    2'b11:   dec_op = ALU_SLTU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec_a  = pc;
                dec_b  = XLEN'(4);
                dec_wb = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase

        // Illegal encodings issue a harmless ADD of zeros and never write back.
        if (!dec_legal) begin
            dec_a  = '0;
            dec_b  = '0;
            dec_op = ALU_ADD;
            dec_wb = 1'b0;
        end
        if (rd == 5'd0) begin
            dec_wb = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_alu_op    <= ALU_ADD;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
            ex_pc        <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            ex_valid     <= 1'b0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_alu_op    <= ALU_ADD;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
            ex_pc        <= '0;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            ex_a         <= dec_a;
            ex_b         <= dec_b;
            ex_alu_op    <= dec_op;
            ex_rd        <= rd;
            ex_reg_write <= dec_wb;
            ex_illegal   <= !dec_legal;
            ex_pc        <= pc;
        end
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that drives the ALU's operand/opcode interface. It takes a fetched RV32I instruction plus register-file read data and PC, decodes opcode/funct3/funct7 into an `alu_op_t` selection, and selects/generates operands A and B. Results are registered into an ID/EX pipeline register with stall and flush control. The registered outputs feed the ALU's `A`, `B` and `ALUControl` inputs directly in the EX stage.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. RV32I decode only; `XLEN` > 32 sign-extends immediates to `XLEN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous active-high reset
- `in_valid`  in  1  `instr`/`pc`/`rs*_data` hold a real instruction this cycle
- `stall`  in  1  hold the pipeline register
- `flush`  in  1  squash: load a bubble
- `instr`  in  32  instruction word
- `pc`  in  XLEN  instruction address
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data
- `ex_valid`  out  1  EX stage holds a valid instruction
- `ex_a`, `ex_b`  out  XLEN  ALU operands
- `ex_alu_op`  out  alu_op_t  ALU operation
- `ex_rd`  out  5  destination register
- `ex_reg_write`  out  1  writeback enable
- `ex_illegal`  out  1  unsupported encoding
- `ex_pc`  out  XLEN  PC of the EX instruction

## Operation
Decode is combinational. Immediates are sign-extended from `instr[31]`:
- I-type: `instr[31:20]`.
- S-type: `{instr[31:25], instr[11:7]}`.
- U-type: `{instr[31:12], 12'b0}`.

Per opcode:
- OP (0110011): A=rs1, B=rs2. By funct3:
  - 000: ADD, or SUB if funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA if funct7=0100000.
  - 110: OR.
  - 111: AND.
  - funct7 must be 0000000; 0100000 is allowed only with funct3 000/101. Anything else is illegal.
- OP-IMM (0010011): A=rs1, B=I-imm, same funct3 map. funct3 000 is always ADD.
  - SLLI requires `instr[31:25]`=0000000.
  - SRLI/SRAI require `instr[31:25]` = 0000000 or 0100000; otherwise illegal.
- LUI (0110111): A=0, B=U-imm, ADD.
- AUIPC (0010111): A=pc, B=U-imm, ADD.
- LOAD (0000011): A=rs1, B=I-imm, ADD.
- STORE (0100011): A=rs1, B=S-imm, ADD, no writeback.
- BRANCH (1100011): A=rs1, B=rs2, no writeback. By funct3:
  - 000/001: SUB.
  - 100/101: SLT.
  - 110/111: SLTU.
  - 010/011: illegal.
- JAL (1101111) / JALR (1100111): A=pc, B=4, ADD (link value).
- Any other opcode is illegal.

Writeback:
- `reg_write` = 1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR.
- `reg_write` is forced 0 when rd = 0, and when the encoding is illegal.

Illegal encoding: A=0, B=0, op=ALU_ADD, `ex_illegal`=1. `ex_valid` still follows `in_valid`.

## Timing
- Reset (asynchronous assert, outputs go immediately): all outputs 0, `ex_alu_op`=ALU_ADD.
- Register update on each `clk` rising edge, priority `flush` > `stall` > load:
  - `flush`=1: load a bubble (all outputs 0, op ALU_ADD), regardless of `stall`.
  - `stall`=1, `flush`=0: hold every output.
  - Otherwise, if `in_valid`=1, load the decoded fields.
  - Otherwise, if `in_valid`=0, load a bubble.
- Latency: exactly 1 cycle from inputs to `ex_*`. There is no combinational path from inputs to outputs.
- Reset asserted mid-stall clears the register; the first edge after deassert loads normally.

## Test plan
- SUB: `instr`=0x402081B3, rs1=10, rs2=3, `in_valid`=1 -> next cycle `ex_alu_op`=ALU_SUB, `ex_a`=10, `ex_b`=3, `ex_rd`=3, `ex_reg_write`=1, `ex_valid`=1.
- SRAI: `instr`=0x40435293, rs1=0x80000000 -> ALU_SRA, `ex_a`=0x80000000, `ex_b`=0x00000404, `ex_rd`=5.
- AUIPC: `instr`=0x12345097, `pc`=0x100 -> ALU_ADD, `ex_a`=0x100, `ex_b`=0x12345000, `ex_rd`=1.
- BLTU: `instr`=0x0020E063 -> ALU_SLTU, `ex_reg_write`=0.
- Illegal (funct7=0000001): `instr`=0x022081B3 -> `ex_illegal`=1, `ex_reg_write`=0, `ex_a`=`ex_b`=0.
- Control:
  - `stall`=1 for 3 cycles holds the prior SUB outputs unchanged.
  - `stall`=1 with `flush`=1 -> bubble (`ex_valid`=0).
  - `rst` pulse mid-stall -> outputs 0 before the next edge.
